register_file: RTL and testbench
================================

# register_file

Parametrised CPU register file: `PAIRS` register pairs of `2*BYTE_W` bits, addressable as individual bytes or as whole pairs. It has three write sources: a byte write, a pair write, and an increment/decrement unit (IDU) that updates a pair in place. Two combinational read ports serve the ALU/datapath. It replaces discrete per-register storage in the CPU core (B/C, D/E, H/L, S/P for `PAIRS=4`), and its clock gating follows the system tick enable.

## Interface
- `BYTE_W`, default 8: byte width; a pair is `2*BYTE_W` bits.
- `PAIRS`, default 4: number of register pairs; byte count is `2*PAIRS`.
- `INITIAL`, default 0: `2*BYTE_W`-bit reset value loaded into every pair.
- `i_Clk`, in, 1: system clock; all state updates on its rising edge.
- `i_nRst`, in, 1: reset, synchronous and active-low.
- `i_Enable`, in, 1: system tick enable; when low, no state changes except reset.
- `i_ByteWrite`, in, 1: byte write request.
- `i_ByteSel`, in, `$clog2(2*PAIRS)`: byte index. Index `2p` is the high byte of pair `p`; index `2p+1` is the low byte.
- `i_ByteData`, in, `BYTE_W`: byte write data.
- `i_PairWrite`, in, 1: pair write request.
- `i_PairSel`, in, `$clog2(PAIRS)`: pair write target.
- `i_PairData`, in, `2*BYTE_W`: pair write data.
- `i_IduOp`, in, 2: IDU operation. 00 = none, 01 = increment, 10 = decrement, 11 = reserved (treated as none).
- `i_IduSel`, in, `$clog2(PAIRS)`: IDU target pair.
- `i_RdByteSel`, in, `$clog2(2*PAIRS)`: byte read index.
- `o_RdByte`, out, `BYTE_W`: selected byte (combinational).
- `i_RdPairSel`, in, `$clog2(PAIRS)`: pair read index.
- `o_RdPair`, out, `2*BYTE_W`: selected pair, high byte in the MSBs (combinational).
- `o_IduWrap`, out, 1: registered. High when the last enabled-edge IDU operation wrapped.

## Operation
- **Reset.** On a rising edge with `i_nRst`=0, every pair is loaded with `INITIAL` and `o_IduWrap` is cleared to 0.
  - Reset applies regardless of `i_Enable` and overrides all write requests on that edge.
- **Enable.** On an edge with `i_nRst`=1 and `i_Enable`=0, all pairs and `o_IduWrap` hold.
- **Enabled edge, per pair `p`, priority order:**
  - Pair write to `p` wins: `p` ← `i_PairData`.
  - Otherwise, an IDU op on `p` wins: `p` ← `p ± 1`, modulo `2^(2*BYTE_W)`.
  - Otherwise, a byte write to byte `2p` or `2p+1` replaces that byte only; the other byte is untouched.
  - Writes to different pairs proceed in parallel. A byte write, a pair write and an IDU op can all land on the same edge if their targets are distinct.
- **Suppressed requests.** A losing request on the same pair is dropped silently; it is not deferred.
- **IDU wrap arithmetic.**
  - Increment: `FFFF` → `0000` (for `BYTE_W`=8) sets the wrap bit.
  - Decrement: `0000` → `FFFF` sets the wrap bit.
  - The carry propagates across the byte boundary, e.g. `00FF` + 1 = `0100`.
- **`o_IduWrap` update.** On every enabled edge, `o_IduWrap` is set to 1 only if an IDU op was performed and wrapped. Otherwise it is set to 0, including when there was no op, a reserved op, or the op was suppressed by a pair write.
- **Out-of-range selects** (when `PAIRS` is not a power of two):
  - Writes to nonexistent indices are ignored.
  - Reads of nonexistent indices return 0.
- **Reads** reflect current register state only. There is no write-to-read bypass.

## Timing
- Write latency is 1 cycle: data presented before edge N is visible on the read ports after edge N.
- `o_IduWrap` is valid in the cycle after the IDU edge. It stays high for exactly one enabled edge unless the next op also wraps.
- Read ports are purely combinational from the register state and the select inputs. There is no read latency.
- Reset deasserted: the first enabled edge with `i_nRst`=1 performs normal writes.
- Reset asserted mid-operation: any pending request on that edge is discarded.

## Test plan
- **Reset and byte writes.** Reset with `INITIAL`=16'h0000. Then byte-write index 0 ← `12` and index 1 ← `34` on consecutive enabled edges. Required: `o_RdPair` for pair 0 = `1234` after the second edge, and `o_RdByte` for index 1 = `34`.
- **Wrap both directions.** Pair-write pair 2 ← `FFFF`, then IDU increment on pair 2. Required: pair 2 = `0000` and `o_IduWrap`=1 for one cycle. A subsequent decrement gives `FFFF` with `o_IduWrap`=1; a further no-op edge drops `o_IduWrap` to 0.
- **Same-pair collision.** On one edge, pair write pair 1 ← `ABCD`, IDU increment pair 1, and byte write index 2 ← `55`. Required: pair 1 = `ABCD` and `o_IduWrap`=0.
  - Then pair 1 = `00FF` and IDU increment with a byte write to index 3: required pair 1 = `0100`.
- **Parallel distinct targets.** On one edge: byte write index 0 ← `77`, pair write pair 1 ← `1111`, IDU decrement pair 3 from `0005`. Required after the edge: pair 0 high byte = `77`, pair 1 = `1111`, pair 3 = `0004`.
- **Enable hold and reset precedence.** With `i_Enable`=0, all write requests are active for 3 edges: required, no state change. Then assert `i_nRst`=0 with `i_Enable`=0 and writes active: required, all pairs = `INITIAL` and `o_IduWrap`=0 after that edge.

Source files
------------

// File: rtl/register_file.sv
// Byte/pair addressable CPU register file with an in-place increment/decrement unit.
// Byte index 2p is the high byte of pair p, 2p+1 the low byte.
module register_file #(
  parameter int          BYTE_W  = 8,
  parameter int          PAIRS   = 4,
  parameter logic [2*BYTE_W-1:0] INITIAL = '0,
  localparam int         PW  = 2 * BYTE_W,
  localparam int         BSW = (2 * PAIRS > 1) ? $clog2(2 * PAIRS) : 1,
  localparam int         PSW = (PAIRS > 1) ? $clog2(PAIRS) : 1
) (
  input  logic             i_Clk,
  input  logic             i_nRst,
  input  logic             i_Enable,
  input  logic             i_ByteWrite,
  input  logic [BSW-1:0]   i_ByteSel,
  input  logic [BYTE_W-1:0] i_ByteData,
  input  logic             i_PairWrite,
  input  logic [PSW-1:0]   i_PairSel,
  input  logic [PW-1:0]    i_PairData,
  input  logic [1:0]       i_IduOp,
  input  logic [PSW-1:0]   i_IduSel,
  input  logic [BSW-1:0]   i_RdByteSel,
  output logic [BYTE_W-1:0] o_RdByte,
  input  logic [PSW-1:0]   i_RdPairSel,
  output logic [PW-1:0]    o_RdPair,
  output logic             o_IduWrap
);

  logic [PW-1:0] r_Pair [PAIRS];
  logic          r_Wrap;

  logic [PW-1:0] w_Next [PAIRS];
  logic          w_Wrap;
  logic          w_Inc;
  logic          w_Dec;

  assign w_Inc = (i_IduOp == 2'b01);
  assign w_Dec = (i_IduOp == 2'b10);

  // Selects matched by loop so out-of-range indices never hit a pair.
  always_comb begin
    w_Wrap = 1'b0;
    for (int p = 0; p < PAIRS; p++) begin
      w_Next[p] = r_Pair[p];
      if (i_PairWrite && (i_PairSel == PSW'(p))) begin
        w_Next[p] = i_PairData;
      end else if ((w_Inc || w_Dec) && (i_IduSel == PSW'(p))) begin
        if (w_Inc) begin
          w_Next[p] = r_Pair[p] + PW'(1);
          w_Wrap    = (r_Pair[p] == {PW{1'b1}});
        end else begin
          w_Next[p] = r_Pair[p] - PW'(1);
          w_Wrap    = (r_Pair[p] == '0);
        end
      end else if (i_ByteWrite) begin
        if (i_ByteSel == BSW'(2 * p))
          w_Next[p][PW-1:BYTE_W] = i_ByteData;
        else if (i_ByteSel == BSW'(2 * p + 1))
          w_Next[p][BYTE_W-1:0] = i_ByteData;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_nRst) begin
      for (int p = 0; p < PAIRS; p++) r_Pair[p] <= INITIAL;
      r_Wrap <= 1'b0;
    end else if (i_Enable) begin
      for (int p = 0; p < PAIRS; p++) r_Pair[p] <= w_Next[p];
      r_Wrap <= w_Wrap;
    end
  end

  assign o_IduWrap = r_Wrap;

  always_comb begin
    o_RdByte = '0;
    o_RdPair = '0;
    for (int p = 0; p < PAIRS; p++) begin
      if (i_RdByteSel == BSW'(2 * p))
        o_RdByte = r_Pair[p][PW-1:BYTE_W];
      if (i_RdByteSel == BSW'(2 * p + 1))
        o_RdByte = r_Pair[p][BYTE_W-1:0];
      if (i_RdPairSel == PSW'(p))
        o_RdPair = r_Pair[p];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed vector bench for register_file (BYTE_W=8, PAIRS=4, INITIAL=0).
// Vectors are applied at negedge and checked 1ns after posedge.
module tb_register_file;

  logic        clk = 1'b0;
  logic        nrst, en, bw, pw;
  logic [2:0]  bsel, rbsel;
  logic [1:0]  psel, isel, op, rpsel;
  logic [7:0]  bdata, rbyte;
  logic [15:0] pdata, rpair;
  logic        wrap;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  register_file #(.BYTE_W(8), .PAIRS(4), .INITIAL(16'h0000)) dut (
    .i_Clk       (clk),
    .i_nRst      (nrst),
    .i_Enable    (en),
    .i_ByteWrite (bw),
    .i_ByteSel   (bsel),
    .i_ByteData  (bdata),
    .i_PairWrite (pw),
    .i_PairSel   (psel),
    .i_PairData  (pdata),
    .i_IduOp     (op),
    .i_IduSel    (isel),
    .i_RdByteSel (rbsel),
    .o_RdByte    (rbyte),
    .i_RdPairSel (rpsel),
    .o_RdPair    (rpair),
    .o_IduWrap   (wrap)
  );

  typedef struct {
    string       nm;
    logic        nrst, en, bw;
    logic [2:0]  bsel;
    logic [7:0]  bdata;
    logic        pw;
    logic [1:0]  psel;
    logic [15:0] pdata;
    logic [1:0]  op, isel;
    logic [2:0]  rbsel;
    logic [1:0]  rpsel;
    logic [7:0]  eb;
    logic [15:0] ep;
    logic        ew;
  } vec_t;

  vec_t vec [15];

  function automatic vec_t mk(string nm, logic r, logic e,
    logic b, logic [2:0] bs, logic [7:0] bd,
    logic p, logic [1:0] ps, logic [15:0] pd,
    logic [1:0] o, logic [1:0] is,
    logic [2:0] rb, logic [1:0] rp,
    logic [7:0] eb, logic [15:0] ep, logic ew);
    vec_t v;
    v.nm = nm; v.nrst = r; v.en = e;
    v.bw = b; v.bsel = bs; v.bdata = bd;
    v.pw = p; v.psel = ps; v.pdata = pd;
    v.op = o; v.isel = is;
    v.rbsel = rb; v.rpsel = rp;
    v.eb = eb; v.ep = ep; v.ew = ew;
    return v;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(vec_t v);
    nrst = v.nrst; en = v.en;
    bw = v.bw; bsel = v.bsel; bdata = v.bdata;
    pw = v.pw; psel = v.psel; pdata = v.pdata;
    op = v.op; isel = v.isel;
    rbsel = v.rbsel; rpsel = v.rpsel;
  endtask

  task automatic chk_pairs(string nm, logic [15:0] e0, logic [15:0] e1,
                           logic [15:0] e2, logic [15:0] e3, logic ew);
    logic [15:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int p = 0; p < 4; p++) begin
      rpsel = 2'(p);
      #1;
      chk($sformatf("%s_pair%0d", nm, p), rpair, e[p]);
    end
    chk({nm, "_wrap"}, 16'(wrap), 16'(ew));
  endtask

  initial begin
    vec[0]  = mk("reset",      0,1, 0,0,8'h00, 0,0,16'h0000, 2'b00,0, 0,0, 8'h00,16'h0000,0);
    vec[1]  = mk("bw_hi",      1,1, 1,0,8'h12, 0,0,16'h0000, 2'b00,0, 0,0, 8'h12,16'h1200,0);
    vec[2]  = mk("bw_lo",      1,1, 1,1,8'h34, 0,0,16'h0000, 2'b00,0, 1,0, 8'h34,16'h1234,0);
    vec[3]  = mk("pw_ffff",    1,1, 0,0,8'h00, 1,2,16'hFFFF, 2'b00,0, 4,2, 8'hFF,16'hFFFF,0);
    vec[4]  = mk("inc_wrap",   1,1, 0,0,8'h00, 0,0,16'h0000, 2'b01,2, 5,2, 8'h00,16'h0000,1);
    vec[5]  = mk("dec_wrap",   1,1, 0,0,8'h00, 0,0,16'h0000, 2'b10,2, 4,2, 8'hFF,16'hFFFF,1);
    vec[6]  = mk("wrap_drop",  1,1, 0,0,8'h00, 0,0,16'h0000, 2'b00,0, 5,2, 8'hFF,16'hFFFF,0);
    vec[7]  = mk("collide",    1,1, 1,2,8'h55, 1,1,16'hABCD, 2'b01,1, 2,1, 8'hAB,16'hABCD,0);
    vec[8]  = mk("pw_00ff",    1,1, 0,0,8'h00, 1,1,16'h00FF, 2'b00,0, 3,1, 8'hFF,16'h00FF,0);
    vec[9]  = mk("inc_carry",  1,1, 1,3,8'hAA, 0,0,16'h0000, 2'b01,1, 3,1, 8'h00,16'h0100,0);
    vec[10] = mk("pw_0005",    1,1, 0,0,8'h00, 1,3,16'h0005, 2'b00,0, 6,3, 8'h00,16'h0005,0);
    vec[11] = mk("parallel",   1,1, 1,0,8'h77, 1,1,16'h1111, 2'b10,3, 0,3, 8'h77,16'h0004,0);
    vec[12] = mk("par_p1",     1,1, 0,0,8'h00, 0,0,16'h0000, 2'b00,0, 2,1, 8'h11,16'h1111,0);
    vec[13] = mk("inc_p0",     1,1, 0,0,8'h00, 0,0,16'h0000, 2'b01,0, 1,0, 8'h35,16'h7735,0);
    vec[14] = mk("inc_p2",     1,1, 0,0,8'h00, 0,0,16'h0000, 2'b01,2, 4,2, 8'h00,16'h0000,1);

    drive(vec[0]);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vec[i]);
      @(posedge clk);
      #1;
      chk({vec[i].nm, "_byte"}, 16'(rbyte), 16'(vec[i].eb));
      chk({vec[i].nm, "_pair"}, rpair, vec[i].ep);
      chk({vec[i].nm, "_wrap"}, 16'(wrap), 16'(vec[i].ew));
    end

    // Disabled edges with every request active must change nothing.
    @(negedge clk);
    en = 0; nrst = 1;
    bw = 1; bsel = 3'd0; bdata = 8'h00;
    pw = 1; psel = 2'd1; pdata = 16'h0000;
    op = 2'b10; isel = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    chk_pairs("hold", 16'h7735, 16'h1111, 16'h0000, 16'h0004, 1'b1);

    // Reset wins over disabled enable and pending writes.
    @(negedge clk);
    nrst = 0;
    @(posedge clk);
    #1;
    chk_pairs("rst_prec", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);

    // First enabled edge after reset performs the write.
    @(negedge clk);
    nrst = 1; en = 1; bw = 0; op = 2'b11;
    pw = 1; psel = 2'd3; pdata = 16'hBEEF;
    @(posedge clk);
    #1;
    chk_pairs("post_rst", 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
